// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic intersection sensor front end.
package traffic_pkg;

    localparam int NUM_LANES = 4;

    // Lane order inside packed lane vectors: {w,s,e,n}
    localparam int LANE_N = 0;
    localparam int LANE_E = 1;
    localparam int LANE_S = 2;
    localparam int LANE_W = 3;

    localparam int LT_NS_G0 = 7;
    localparam int LT_NS_G1 = 3;
    localparam int LT_EW_G0 = 5;
    localparam int LT_EW_G1 = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB    = 2'd1,
        PEND   = 2'd2,
        SERVED = 2'd3
    } lane_state_t;

endpackage

// File: rtl/traffic_lane_sensor.sv
// One detector lane: 2-flop synchronizer, debounce/latch FSM and stuck-sensor watchdog.
module traffic_lane_sensor
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 4,
    parameter int STUCK_CYCLES = 200,
    parameter int STUCK_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic served,
    output logic req,
    output logic fault
);

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);
    localparam logic               DEB_ONE   = (DEB_CYCLES == 1);

    logic                sync_q1;
    logic                sync;
    lane_state_t         state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [STUCK_W-1:0]  stuck, stuck_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync    <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            stuck   <= '0;
            req     <= 1'b0;
            fault   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync    <= sync_q1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stuck   <= stuck_nxt;
            // Outputs follow the next state so they line up with the state register
            req     <= (state_nxt == PEND);
            fault   <= (state_nxt == SERVED) && (stuck_nxt == STUCK_MAX);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stuck_nxt = stuck;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sync) begin
                    if (DEB_ONE) begin
                        state_nxt = PEND;
                    end else begin
                        state_nxt = DEB;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DEB: begin
                // A vehicle already rolling through on green never raises a request
                if (served) begin
                    state_nxt = SERVED;
                    cnt_nxt   = '0;
                    stuck_nxt = '0;
                end else if (!sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PEND;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PEND: begin
                if (served) begin
                    state_nxt = SERVED;
                    cnt_nxt   = '0;
                    stuck_nxt = '0;
                end
            end
            SERVED: begin
                if (sync) begin
                    cnt_nxt = '0;
                    if (stuck != STUCK_MAX)
                        stuck_nxt = stuck + STUCK_W'(1);
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    stuck_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                stuck_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Front end for the intersection: green decode from the light bus and four lane conditioners.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 4,
    parameter int STUCK_CYCLES = 200,
    parameter int STUCK_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_n,
    input  logic       raw_e,
    input  logic       raw_s,
    input  logic       raw_w,
    input  logic [7:0] lights,
    output logic       n,
    output logic       e,
    output logic       s,
    output logic       w,
    output logic [3:0] sensor_fault
);

    logic ns_green;
    logic ew_green;
    logic unused_lights;
    logic [NUM_LANES-1:0] raw_vec;
    logic [NUM_LANES-1:0] served_vec;
    logic [NUM_LANES-1:0] req_vec;
    logic [NUM_LANES-1:0] fault_vec;

    // Only the green bits matter; yellow and red never serve a request
    assign ns_green      = lights[LT_NS_G0] | lights[LT_NS_G1];
    assign ew_green      = lights[LT_EW_G0] | lights[LT_EW_G1];
    assign unused_lights = ^{lights[6], lights[4], lights[2], lights[0]};

    assign raw_vec    = {raw_w, raw_s, raw_e, raw_n};
    assign served_vec = {ew_green, ns_green, ew_green, ns_green};

    for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
        traffic_lane_sensor #(
            .DEB_CYCLES   (DEB_CYCLES),
            .CNT_W        (CNT_W),
            .STUCK_CYCLES (STUCK_CYCLES),
            .STUCK_W      (STUCK_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_vec[i]),
            .served (served_vec[i]),
            .req    (req_vec[i]),
            .fault  (fault_vec[i])
        );
    end

    assign n            = req_vec[LANE_N];
    assign e            = req_vec[LANE_E];
    assign s            = req_vec[LANE_S];
    assign w            = req_vec[LANE_W];
    assign sensor_fault = fault_vec;

endmodule
